// File: rtl/vector_stream_out.sv
// Drains consecutive vector words from the data memory onto a lane-serial valid/ready stream.
// Define VSO_CHECKSUM_EN to add the running checksum output.
module vector_stream_out #(
  parameter int DATA_WIDTH    = 16,
  parameter int VECTOR_SIZE   = 6,
  parameter int ADDRESS_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDRESS_WIDTH-1:0]          baseAddress,
  input  logic [COUNT_WIDTH-1:0]            vectorCount,
  output logic                              memReadEnable,
  output logic [ADDRESS_WIDTH-1:0]          memReadAddress,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] memReadData,
  output logic [DATA_WIDTH-1:0]             outData,
  output logic                              outValid,
  input  logic                              outReady,
  output logic                              outLast,
  output logic                              busy,
  output logic                              done
`ifdef VSO_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]             checksum
`endif
);

  localparam int LANE_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_STREAM, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]          base_q, base_d;
  logic [COUNT_WIDTH-1:0]            count_q, count_d;
  logic [COUNT_WIDTH-1:0]            vidx_q, vidx_d;
  logic [LANE_W-1:0]                 lane_q, lane_d;
  logic [DATA_WIDTH*VECTOR_SIZE-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0]             lanes [VECTOR_SIZE];
  logic                              last_lane, last_vec;

  for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
    assign lanes[gi] = buf_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign last_lane = (lane_q == LAST_LANE);
  // Widened by one bit so vectorCount = 2^COUNT_WIDTH-1 terminates correctly.
  assign last_vec  = (({1'b0, vidx_q} + (COUNT_WIDTH+1)'(1)) >= {1'b0, count_q});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      vidx_q  <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      vidx_q  <= vidx_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    count_d        = count_q;
    vidx_d         = vidx_q;
    lane_d         = lane_q;
    buf_d          = buf_q;
    memReadEnable  = 1'b0;
    memReadAddress = '0;
    outValid       = 1'b0;
    outData        = '0;
    outLast        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = baseAddress;
          count_d = vectorCount;
          vidx_d  = '0;
          lane_d  = '0;
          state_d = (vectorCount != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy           = 1'b1;
        memReadEnable  = 1'b1;
        memReadAddress = base_q + ADDRESS_WIDTH'(vidx_q);
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        buf_d   = memReadData;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        busy     = 1'b1;
        outValid = 1'b1;
        outData  = lanes[lane_q];
        outLast  = last_lane && last_vec;
        if (outReady) begin
          if (last_lane) begin
            lane_d = '0;
            if (last_vec) begin
              state_d = S_DONE;
            end else begin
              vidx_d  = vidx_q + COUNT_WIDTH'(1);
              state_d = S_READ;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef VSO_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE && start) begin
      sum_d = '0;
    end else if (state_q == S_STREAM && outReady) begin
      sum_d = sum_q + outData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_vector_stream_out.sv
// Randomized bench for vector_stream_out: a transaction-level model predicts reads, elements and
// handshake timing; directed cases pin the model with hand-computed cycle offsets and values.
module tb_vector_stream_out;
  localparam int DW = 16;
  localparam int VS = 6;
  localparam int AW = 16;
  localparam int CW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     baseAddress = '0;
  logic [CW-1:0]     vectorCount = '0;
  logic              memReadEnable;
  logic [AW-1:0]     memReadAddress;
  logic [DW*VS-1:0]  memReadData = '0;
  logic [DW-1:0]     outData;
  logic              outValid;
  logic              outReady = 1'b1;
  logic              outLast;
  logic              busy;
  logic              done;
`ifdef VSO_CHECKSUM_EN
  logic [DW-1:0]     checksum;
`endif

  vector_stream_out #(
    .DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .baseAddress(baseAddress), .vectorCount(vectorCount),
    .memReadEnable(memReadEnable), .memReadAddress(memReadAddress), .memReadData(memReadData),
    .outData(outData), .outValid(outValid), .outReady(outReady), .outLast(outLast),
    .busy(busy), .done(done)
`ifdef VSO_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: explicit overrides, otherwise an address-derived pattern.
  logic [DW*VS-1:0] mem_over [logic [AW-1:0]];

  function automatic logic [DW*VS-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW*VS-1:0] w;
    if (mem_over.exists(a)) return mem_over[a];
    for (int l = 0; l < VS; l++) w[l*DW +: DW] = 16'(32'(a) * 7 + l * 13 + 32'h5A5);
    return w;
  endfunction

  function automatic logic [DW*VS-1:0] ramp();
    logic [DW*VS-1:0] w;
    for (int l = 0; l < VS; l++) w[l*DW +: DW] = 16'(l + 1);
    return w;
  endfunction

  // Read data is only meaningful the cycle after the strobe; garbage otherwise.
  always @(posedge clock)
    memReadData <= memReadEnable ? mem_word(memReadAddress) : {$urandom, $urandom, $urandom};

  typedef struct packed {logic [DW-1:0] d; logic last;} elem_t;
  elem_t         exp_q [$];
  logic [AW-1:0] addr_q [$];
  bit m_active, m_read_due, m_wait, m_stream, m_done_now;
  bit nxt_active, nxt_read, nxt_wait, nxt_stream, nxt_done;
  int m_lane;
  logic [DW-1:0] m_sum;
  bit prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_last;
  elem_t e;

  int cyc = 0;
  int t_start, t_done, busy_cycles, valid_cycles, stall3_cycles, last_count;
  bit done_seen;
  logic [DW-1:0] rx [$];
  int            rx_cyc [$];
  bit            rx_last [$];
  int            read_cyc [$];
  logic [AW-1:0] read_addr [$];

  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      chk("rst_rd_en", memReadEnable, 0);
      chk("rst_rd_addr", memReadAddress, 0);
      chk("rst_valid", outValid, 0);
      chk("rst_data", outData, 0);
      chk("rst_last", outLast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef VSO_CHECKSUM_EN
      chk("rst_checksum", checksum, 0);
`endif
      exp_q.delete();
      addr_q.delete();
      m_active = 0; m_read_due = 0; m_wait = 0; m_stream = 0; m_done_now = 0;
      m_lane = 0; m_sum = '0; prev_stall = 0;
    end else begin
      chk("busy", busy, m_active);
      chk("done", done, m_done_now);
      chk("rd_en", memReadEnable, m_read_due);
      chk("valid", outValid, m_stream);
`ifdef VSO_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
      if (busy) busy_cycles++;
      if (done) begin done_seen = 1; t_done = cyc; end
      if (memReadEnable) begin
        read_cyc.push_back(cyc);
        read_addr.push_back(memReadAddress);
        if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", memReadAddress, addr_q.pop_front());
      end
      if (outValid) begin
        valid_cycles++;
        if (prev_stall) begin
          chk("hold_data", outData, prev_data);
          chk("hold_last", outLast, prev_last);
        end
        if (!outReady && outData == 16'd3) stall3_cycles++;
        if (exp_q.size() == 0) chk("extra_elem", 1, 0);
        else begin
          chk("data", outData, exp_q[0].d);
          chk("last", outLast, exp_q[0].last);
        end
      end
      nxt_active = m_active && !m_done_now;
      nxt_read   = 0;
      nxt_done   = 0;
      nxt_wait   = m_read_due;
      nxt_stream = m_stream || m_wait;
      if (!m_active && start) begin
        nxt_active = 1;
        m_sum = '0;
        t_start = cyc;
        busy_cycles = 0; valid_cycles = 0; stall3_cycles = 0; last_count = 0;
        rx.delete(); rx_cyc.delete(); rx_last.delete(); read_cyc.delete(); read_addr.delete();
        for (int v = 0; v < int'(vectorCount); v++) begin
          addr_q.push_back(AW'(32'(baseAddress) + v));
          for (int l = 0; l < VS; l++)
            exp_q.push_back({mem_word(AW'(32'(baseAddress) + v)) >> (l*DW),
                             1'b0} | elem_t'((v == int'(vectorCount) - 1 && l == VS - 1) ? 1 : 0));
        end
        if (vectorCount == '0) nxt_done = 1;
        else nxt_read = 1;
      end
      if (m_stream && outReady) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          m_sum = m_sum + e.d;
        end
        rx.push_back(outData);
        rx_cyc.push_back(cyc);
        rx_last.push_back(outLast);
        if (outLast) last_count++;
        m_lane++;
        if (m_lane == VS) begin
          m_lane = 0;
          nxt_stream = 0;
          if (exp_q.size() == 0) nxt_done = 1;
          else nxt_read = 1;
        end
      end
      prev_stall = outValid && !outReady;
      prev_data  = outData;
      prev_last  = outLast;
      m_active = nxt_active; m_read_due = nxt_read; m_wait = nxt_wait;
      m_stream = nxt_stream; m_done_now = nxt_done;
    end
  end

  // 0: always ready, 1: random ready, 2: stall three cycles on element value 3
  int ready_mode = 0;
  int stall_n = 0;
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      1: outReady = ($urandom % 4) != 0;
      2: if (outValid && outData == 16'd3 && stall_n < 3) begin
           outReady = 0;
           stall_n++;
         end else outReady = 1;
      default: outReady = 1;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] c);
    done_seen   = 0;
    start       = 1;
    baseAddress = b;
    vectorCount = c;
    tick();
    start       = 0;
    baseAddress = AW'($urandom);
    vectorCount = CW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit spurious);
    int n = 0;
    while (!done_seen && n < budget) begin
      start = spurious ? (($urandom % 8) == 0) : 1'b0;
      tick();
      n++;
    end
    start = 0;
    if (!done_seen) chk("timeout_waiting_done", 0, 1);
    tick();
  endtask

  task automatic check_ramp(input string name);
    chk({name, "_count"}, rx.size(), VS);
    for (int i = 0; i < VS; i++)
      chk(name, (i < rx.size()) ? rx[i] : 16'hxxxx, 16'(i + 1));
  endtask

  initial begin
    mem_over[16'h0010] = ramp();
    mem_over[16'h0020] = ramp();
    mem_over[16'h0021] = ramp();

    repeat (3) tick();
    @(posedge clock); #3 reset = 1;
    tick();

    // single vector at 0x0010
    ready_mode = 0;
    pulse_start(16'h0010, 1);
    wait_done(100, 0);
    check_ramp("single_seq");
    chk("single_rd_cnt", read_cyc.size(), 1);
    chk("single_rd_cyc", read_cyc.size() > 0 ? read_cyc[0] - t_start : -1, 1);
    chk("single_rd_addr", read_addr.size() > 0 ? read_addr[0] : 'x, 16'h0010);
    chk("single_first_cyc", rx_cyc.size() > 0 ? rx_cyc[0] - t_start : -1, 3);
    chk("single_last_cyc", rx_cyc.size() > 5 ? rx_cyc[5] - t_start : -1, 8);
    chk("single_last_flag", rx_last.size() > 5 ? rx_last[5] : 0, 1);
    chk("single_last_count", last_count, 1);
    chk("single_done_cyc", t_done - t_start, 9);

    // backpressure on lane value 3
    ready_mode = 2;
    stall_n = 0;
    pulse_start(16'h0010, 1);
    wait_done(100, 0);
    check_ramp("bp_seq");
    chk("bp_stall_cycles", stall3_cycles, 3);
    chk("bp_done_cyc", t_done - t_start, 12);
    ready_mode = 0;

    // zero count
    pulse_start(16'h1234, 0);
    wait_done(20, 0);
    chk("zero_done_cyc", t_done - t_start, 1);
    chk("zero_busy_cycles", busy_cycles, 1);
    chk("zero_reads", read_cyc.size(), 0);
    chk("zero_valid_cycles", valid_cycles, 0);

    // address wrap
    pulse_start(16'hFFFF, 2);
    wait_done(100, 0);
    chk("wrap_rd_cnt", read_addr.size(), 2);
    chk("wrap_rd0", read_addr.size() > 0 ? read_addr[0] : 'x, 16'hFFFF);
    chk("wrap_rd1", read_addr.size() > 1 ? read_addr[1] : 'x, 16'h0000);
    chk("wrap_elems", rx.size(), 12);
    chk("wrap_last_count", last_count, 1);
    chk("wrap_last_12th", rx_last.size() > 11 ? rx_last[11] : 0, 1);
    chk("wrap_next_read_cyc", read_cyc.size() > 1 ? read_cyc[1] - read_cyc[0] : -1, VS + 2);

    // asynchronous reset while lane value 2 is presented
    pulse_start(16'h0010, 1);
    for (int n = 0; n < 20 && !(outValid && outData == 16'd2); n++) tick();
    chk("rst_reached_lane2", outValid && outData == 16'd2, 1);
    #2 reset = 0;
    #1;
    chk("midrst_valid", outValid, 0);
    chk("midrst_data", outData, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_addr", memReadAddress, 0);
    tick(); tick();
    @(posedge clock); #3 reset = 1;
    tick();
    tick();
    chk("post_rst_idle_busy", busy, 0);
    pulse_start(16'h0010, 1);
    wait_done(100, 0);
    check_ramp("post_rst_seq");

    // two ramp vectors with a start pulsed mid-stream that must be ignored
    pulse_start(16'h0020, 2);
    for (int n = 0; n < 20 && !outValid; n++) tick();
    start = 1; baseAddress = 16'h0300; vectorCount = 1;
    tick();
    start = 0;
    wait_done(100, 0);
    chk("ign_elems", rx.size(), 12);
    chk("ign_reads", read_addr.size(), 2);
`ifdef VSO_CHECKSUM_EN
    chk("csum_after_done", checksum, 16'h002A);
    repeat (3) tick();
    chk("csum_hold", checksum, 16'h002A);
`endif

    // randomized transactions with random backpressure and spurious starts
    ready_mode = 1;
    for (int i = 0; i < 30; i++) begin
      pulse_start(AW'($urandom), CW'($urandom % 5));
      wait_done(400, 1);
      repeat ($urandom % 3) tick();
    end
    ready_mode = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_stream_out.md
# vector_stream_out

Downstream drain engine for the vector CPU's data memory. On a start pulse it reads a run of consecutive vector words (VECTOR_SIZE lanes of DATA_WIDTH bits) from the data memory's read port. Each vector is buffered and emitted one lane at a time on a valid/ready element stream, so results produced by the pipeline's Memory stage can be shipped to a display, UART or test harness. It owns a read port on the data memory and never writes it.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one vector lane / output element
- VECTOR_SIZE, 6, lanes per memory word
- ADDRESS_WIDTH, 16, data-memory word address width
- COUNT_WIDTH, 16, width of the vector-count input

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- baseAddress  in  ADDRESS_WIDTH  first vector word address, latched on accepted start
- vectorCount  in  COUNT_WIDTH  number of vectors to drain, latched on accepted start
- memReadEnable  out  1  read strobe to data memory
- memReadAddress  out  ADDRESS_WIDTH  read address, valid with memReadEnable
- memReadData  in  DATA_WIDTH*VECTOR_SIZE  read data, valid exactly one cycle after memReadEnable
- outData  out  DATA_WIDTH  current element
- outValid  out  1  element valid
- outReady  in  1  consumer accepts element when outValid&outReady
- outLast  out  1  high with the final element of the final vector
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- checksum  out  DATA_WIDTH  present only with VSO_CHECKSUM_EN

## Operation
- FSM states: IDLE, READ, WAIT, STREAM, DONE.
- IDLE: start=1 latches baseAddress, vectorCount and clears the vector index and lane index. Next state is READ if count≠0, else DONE.
- READ: memReadEnable=1, memReadAddress=base+vectorIndex (mod 2^ADDRESS_WIDTH). Next state is WAIT.
- WAIT: capture memReadData into the lane buffer at the end of the cycle. Next state is STREAM.
- STREAM: outValid=1, outData=buffer lane[laneIndex]. Lane 0 is bits [DATA_WIDTH-1:0] and is sent first.
  - On handshake, laneIndex increments.
  - On handshake of lane VECTOR_SIZE-1: if vectorIndex+1<count, increment vectorIndex, reset laneIndex and go to READ; otherwise go to DONE.
- DONE: done=1, busy=1 for one cycle. Next state is IDLE.
- outLast = STREAM & last lane & last vector.
- While outValid=1 and outReady=0, outData/outLast hold stable. No element is skipped or duplicated.
- start in any state other than IDLE is ignored. No queuing.
- No prefetch: the next read is issued only after the current buffer is fully drained.

## Timing
- Reset (reset=0, asynchronous): state IDLE; all outputs 0, including memReadAddress, outData and checksum; indices 0. Any in-flight read is discarded.
- Reset takes effect mid-transfer in any state. After release, the block waits in IDLE.
- With start accepted at cycle t and outReady held 1:
  - memReadEnable at t+1
  - elements at t+3 … t+2+VECTOR_SIZE
  - next vector's read at t+3+VECTOR_SIZE
- Per-vector cost is VECTOR_SIZE+2 cycles at full throughput.
- done asserts one cycle after the last handshake.
- vectorCount=0: done at t+1; no memReadEnable, no outValid.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH. vectorCount up to 2^COUNT_WIDTH-1 is supported.

## Configuration
- VSO_CHECKSUM_EN defined:
  - Port checksum exists.
  - It is the running sum, modulo 2^DATA_WIDTH, of every accepted element.
  - It is cleared to 0 on accepted start and holds its value after done until the next accepted start.
- VSO_CHECKSUM_EN undefined: port and adder absent. All other behaviour is identical.

## Test plan
- Single vector: mem[0x0010] lanes 1,2,3,4,5,6, base 0x0010, count 1, outReady=1, start at t → memReadEnable/addr 0x0010 at t+1; outData 1..6 at t+3..t+8; outLast only at t+8; done at t+9.
- Backpressure: same setup, outReady=0 for 3 cycles while lane value 3 is presented → outData stays 3; sequence out is exactly 1,2,3,4,5,6.
- Zero count: count 0, start → done at t+1, busy high only at t+1, memReadEnable and outValid never assert.
- Wrap: base 0xFFFF, count 2 → reads at 0xFFFF then 0x0000; 12 elements; outLast only on the 12th.
- Reset mid-STREAM: reset=0 while lane 2 is presented → all outputs 0 immediately. After release, a new start drains correctly from lane 0.
- Checksum (VSO_CHECKSUM_EN) with count 2, both vectors 1..6 → checksum 0x002A after done. A start pulsed during STREAM is ignored and checksum is not cleared.
